// File: rtl/pixels_select_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pixels_select_pkg
//  Description : Shared types and constants for the pixel-select sequencer:
//                FSM state encoding, default parameter values and the
//                select-width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package pixels_select_pkg;

    // Sequencer states. The encoding width is fixed so the state register
    // is exactly two flops.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pixsel_state_t;

    localparam int c_DEF_NUM_PIX = 4;
    localparam int c_DEF_PASS_W  = 8;

    // Width of the select index: max(1, clog2(n)). A single-pixel buffer
    // still needs a one-bit select port.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : pixels_select_pkg
`default_nettype wire

// File: rtl/pixsel_rollover_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : pixsel_rollover_cnt
//  Description : Enabled up-counter with synchronous clear and a parametric
//                rollover value. Counts 0..MAX_VAL and wraps to 0 on the
//                enabled cycle at MAX_VAL. roll_o flags count == MAX_VAL.
//  Revision    : 1.0  initial release
//
//  Ports:
//    clk     in   clock, rising edge
//    n_rst   in   asynchronous active-low reset
//    en_i    in   count enable
//    clr_i   in   synchronous clear (priority over en_i)
//    cnt_o   out  current count (registered)
//    roll_o  out  count is at the rollover value
// ============================================================================
module pixsel_rollover_cnt #(
    parameter int WIDTH   = 2,
    parameter int MAX_VAL = 3
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             roll_o
);

    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Wrapping on ">=" rather than "==" keeps the count inside 0..MAX_VAL
    // even for non-power-of-two ranges, whatever the register holds.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (cnt_q >= c_MAX) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign roll_o = (cnt_q == c_MAX);

endmodule : pixsel_rollover_cnt
`default_nettype wire

// File: rtl/pixels_select_seq.sv
`default_nettype none
// ============================================================================
//  Module      : pixels_select_seq
//  Description : Pixel-select sequencer for the image input buffer. A start
//                launches a pass; each calc_done advances the select index
//                through NUM_PIX pixels. The pass end pulses pass_done for
//                one cycle, bumps pass_cnt and optionally auto-restarts.
//  Revision    : 1.0  initial release
//
//  Optional build macro:
//    PIXSEL_PROTO_CHECK_EN  enables the sticky protocol-error flag err
//                           (calc_done outside RUN, or start inside RUN).
//                           Without it err is tied low.
//
//  Ports:
//    clk          in   clock, rising edge
//    n_rst        in   asynchronous active-low reset
//    start        in   begin a pass (honoured in IDLE and DONE)
//    calc_done    in   current pixel consumed (honoured in RUN)
//    auto_repeat  in   restart from DONE without waiting for start
//    clear        in   synchronous abort to IDLE, clears pass_cnt and err
//    select       out  current pixel index
//    busy         out  sequencer in RUN
//    last         out  RUN and select == NUM_PIX-1
//    pass_done    out  one-cycle pulse in DONE
//    pass_cnt     out  completed passes, wraps modulo 2^PASS_W
//    err          out  sticky protocol error
// ============================================================================
module pixels_select_seq
    import pixels_select_pkg::*;
#(
    parameter  int NUM_PIX = c_DEF_NUM_PIX,
    parameter  int PASS_W  = c_DEF_PASS_W,
    localparam int SEL_W   = sel_width(NUM_PIX)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic              calc_done,
    input  logic              auto_repeat,
    input  logic              clear,
    output logic [SEL_W-1:0]  select,
    output logic              busy,
    output logic              last,
    output logic              pass_done,
    output logic [PASS_W-1:0] pass_cnt,
    output logic              err
);

    pixsel_state_t     state_q;
    pixsel_state_t     state_d;
    logic [PASS_W-1:0] pass_cnt_q;
    logic [PASS_W-1:0] pass_cnt_d;

    logic              sel_en;
    logic              sel_clr;
    logic              sel_roll;
    logic              pass_end;
    logic [SEL_W-1:0]  sel_cnt;

    // ------------------------------------------------------------------
    // Select index. Only advances in RUN; held cleared everywhere else so
    // IDLE and DONE always present select 0 and every pass starts at 0.
    // ------------------------------------------------------------------
    assign sel_en   = (state_q == RUN) && calc_done;
    assign sel_clr  = clear || (state_q != RUN);
    assign pass_end = sel_en && sel_roll;

    pixsel_rollover_cnt #(
        .WIDTH   (SEL_W),
        .MAX_VAL (NUM_PIX - 1)
    ) u_sel_cnt (
        .clk    (clk),
        .n_rst  (n_rst),
        .en_i   (sel_en),
        .clr_i  (sel_clr),
        .cnt_o  (sel_cnt),
        .roll_o (sel_roll)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. clear overrides everything, in every state.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (pass_end) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    state_d = (start || auto_repeat) ? RUN : IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs, decoded from registered state only
    // ------------------------------------------------------------------
    always_comb begin
        busy      = (state_q == RUN);
        last      = (state_q == RUN) && sel_roll;
        pass_done = (state_q == DONE);
    end

    assign select = sel_cnt;

    // ------------------------------------------------------------------
    // Completed-pass counter, wraps naturally at 2^PASS_W
    // ------------------------------------------------------------------
    always_comb begin
        pass_cnt_d = pass_cnt_q;
        if (clear) begin
            pass_cnt_d = '0;
        end else if (pass_end) begin
            pass_cnt_d = pass_cnt_q + PASS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pass_cnt_q <= '0;
        end else begin
            pass_cnt_q <= pass_cnt_d;
        end
    end

    assign pass_cnt = pass_cnt_q;

    // ------------------------------------------------------------------
    // Protocol error flag
    // ------------------------------------------------------------------
`ifdef PIXSEL_PROTO_CHECK_EN
    logic proto_viol;
    logic err_q;
    logic err_d;

    // calc_done is only meaningful in RUN; start is only meaningful
    // outside RUN.
    assign proto_viol = (calc_done && (state_q != RUN)) ||
                        (start && (state_q == RUN));

    always_comb begin
        err_d = err_q;
        if (clear) begin
            err_d = 1'b0;
        end else if (proto_viol) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (n_rst && proto_viol) begin
            $error("pixels_select_seq: protocol violation (state=%0d start=%0b calc_done=%0b)",
                   state_q, start, calc_done);
        end
    end
`endif
`else
    assign err = 1'b0;
`endif

endmodule : pixels_select_seq
`default_nettype wire
